operand2_shifter: RTL and testbench

//  Multi-cycle shifter/rotator producing the ALU B operand and the shifter carry-out
//  for data-processing instructions. Sits directly upstream of the ALU B input.

---
 rtl/operand2_shifter_if.sv | 24 ++
 rtl/operand2_shifter.sv | 173 +++++++++++++++++
 tb/tb_operand2_shifter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand2_shifter_if.sv
// Operand2 shifter request/response bundle.
// Control drives start/mode/imm12/rm/rs_amount/cin; shifter returns b_out/shifter_cout/busy/done.
interface operand2_shifter_if;
  logic        start;
  logic [1:0]  mode;
  logic [11:0] imm12;
  logic [31:0] rm;
  logic [7:0]  rs_amount;
  logic        cin;
  logic [31:0] b_out;
  logic        shifter_cout;
  logic        busy;
  logic        done;

  modport master (
    output start, mode, imm12, rm, rs_amount, cin,
    input  b_out, shifter_cout, busy, done
  );

  modport slave (
    input  start, mode, imm12, rm, rs_amount, cin,
    output b_out, shifter_cout, busy, done
  );
endinterface

// File: rtl/operand2_shifter.sv
// Iterative operand2 shifter/rotator: STEP bits per cycle, feeds ALU B + carry.
// Ports: clk, reset_n (async low), bus (slave: start/mode/imm12/rm/rs_amount/cin -> b_out/shifter_cout/busy/done).
module operand2_shifter #(
  parameter int STEP = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  operand2_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] T_LSL = 2'd0;
  localparam logic [1:0] T_LSR = 2'd1;
  localparam logic [1:0] T_ASR = 2'd2;
  localparam logic [1:0] T_ROR = 2'd3;

  state_e      state_q, state_d;
  logic [32:0] sr_q, sr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  typ_q, typ_d;
  logic        sign_q, sign_d;
  logic        zc_q, zc_d;
  logic [31:0] b_out_q, b_out_d;
  logic        cout_q, cout_d;
  logic        done_q, done_d;

  logic [31:0] ld_val;
  logic        ld_c;
  logic [5:0]  ld_cnt;
  logic [1:0]  ld_typ;
  logic        ld_zc;
  logic [4:0]  amt5;
  logic [1:0]  typ_in;
  logic [7:0]  rs;
  logic [32:0] sh_v;

  assign amt5   = bus.imm12[11:7];
  assign typ_in = bus.imm12[6:5];
  assign rs     = bus.rs_amount;

  // Decode the request into an initial {carry,value}, a count and a type.
  // Special cases resolve here and leave the count at zero.
  always_comb begin
    ld_val = bus.rm;
    ld_c   = bus.cin;
    ld_cnt = 6'd0;
    ld_typ = T_ROR;
    ld_zc  = 1'b0;
    unique case (bus.mode)
      2'b00: begin
        ld_val = {24'd0, bus.imm12[7:0]};
        ld_cnt = {1'b0, bus.imm12[11:8], 1'b0};
      end
      2'b01: begin
        ld_typ = typ_in;
        unique case (typ_in)
          T_LSL: ld_cnt = {1'b0, amt5};
          T_LSR,
          T_ASR: ld_cnt = (amt5 == 5'd0) ? 6'd32
                                         : {1'b0, amt5};
          default: begin
            if (amt5 == 5'd0) begin
              ld_val = {bus.cin, bus.rm[31:1]};
              ld_c   = bus.rm[0];
            end else begin
              ld_cnt = {1'b0, amt5};
            end
          end
        endcase
      end
      2'b10: begin
        ld_typ = typ_in;
        if (rs != 8'd0) begin
          if (typ_in == T_ROR) begin
            if (rs[4:0] == 5'd0) ld_c = bus.rm[31];
            else ld_cnt = {1'b0, rs[4:0]};
          end else begin
            ld_cnt = (rs > 8'd32) ? 6'd32 : rs[5:0];
            ld_zc  = (rs > 8'd32) && (typ_in != T_ASR);
          end
        end
      end
      default: ;
    endcase
  end

  // One SHIFT cycle: up to STEP single-bit moves, bit 32 holds the carry.
  always_comb begin
    sh_v = sr_q;
    for (int i = 0; i < STEP; i++) begin
      if (cnt_q > 6'(i)) begin
        unique case (typ_q)
          T_LSL:   sh_v = {sh_v[31:0], 1'b0};
          T_LSR:   sh_v = {sh_v[0], 1'b0, sh_v[31:1]};
          T_ASR:   sh_v = {sh_v[0], sign_q, sh_v[31:1]};
          default: sh_v = {sh_v[0], sh_v[0], sh_v[31:1]};
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    typ_d   = typ_q;
    sign_d  = sign_q;
    zc_d    = zc_q;
    b_out_d = b_out_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = {ld_c, ld_val};
          cnt_d   = ld_cnt;
          typ_d   = ld_typ;
          sign_d  = bus.rm[31];
          zc_d    = ld_zc;
          state_d = (ld_cnt == 6'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sh_v;
        cnt_d = (cnt_q > 6'(STEP)) ? cnt_q - 6'(STEP)
                                   : 6'd0;
        if (cnt_d == 6'd0) state_d = DONE;
      end
      DONE: begin
        b_out_d = sr_q[31:0];
        cout_d  = sr_q[32] & ~zc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      typ_q   <= T_LSL;
      sign_q  <= 1'b0;
      zc_q    <= 1'b0;
      b_out_q <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      typ_q   <= typ_d;
      sign_q  <= sign_d;
      zc_q    <= zc_d;
      b_out_q <= b_out_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign bus.b_out        = b_out_q;
  assign bus.shifter_cout = cout_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_operand2_shifter.sv
// Scoreboard bench for operand2_shifter: random + directed requests.
// Reference model uses plain 64-bit shift arithmetic; monitor checks value, carry, latency.
module tb_operand2_shifter;
  localparam int STEP = 4;

  typedef struct {
    logic [31:0] b;
    logic        c;
    int          lat;
    int          t0;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cycle;
  int   checks;
  int   errors;
  exp_t sbq[$];
  logic [31:0] last_b;
  logic        last_c;

  operand2_shifter_if bus ();

  operand2_shifter #(.STEP(STEP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] ror32(input logic [31:0] v, input int r);
    return (v >> r) | (v << (32 - r));
  endfunction

  function automatic void model(
    input  logic [1:0]  m,
    input  logic [11:0] imm,
    input  logic [31:0] rm,
    input  logic [7:0]  rs,
    input  logic        cin,
    output logic [31:0] b,
    output logic        c,
    output int          lat
  );
    int k;
    int a;
    logic [1:0] t;
    logic [63:0] x;
    b = rm;
    c = cin;
    k = 0;
    a = 0;
    t = imm[6:5];
    if (m == 2'b00) begin
      k = 2 * int'(imm[11:8]);
      b = {24'd0, imm[7:0]};
      if (k != 0) begin
        b = ror32(b, k);
        c = b[31];
      end
    end else if (m == 2'b01 || m == 2'b10) begin
      if (m == 2'b01) begin
        a = int'(imm[11:7]);
        if (a == 0 && (t == 2'd1 || t == 2'd2)) a = 32;
        if (a == 0 && t == 2'd3) begin
          b = {cin, rm[31:1]};
          c = rm[0];
        end
      end else begin
        a = int'(rs);
        if (a != 0 && t == 2'd3 && (a % 32) == 0) begin
          c = rm[31];
          a = 0;
        end else if (t == 2'd3) begin
          a = a % 32;
        end
      end
      if (a != 0) begin
        k = (a > 32) ? 32 : a;
        case (t)
          2'd0: begin
            x = 64'(rm) << k;
            b = (a > 32) ? 32'd0 : x[31:0];
            c = (a > 32) ? 1'b0 : x[32];
          end
          2'd1: begin
            x = {rm, 32'd0} >> k;
            b = (a > 32) ? 32'd0 : x[63:32];
            c = (a > 32) ? 1'b0 : x[31];
          end
          2'd2: begin
            x = 64'($signed({rm, 32'd0}) >>> k);
            b = x[63:32];
            c = x[31];
          end
          default: begin
            b = ror32(rm, k);
            c = b[31];
          end
        endcase
      end
    end
    lat = 1 + (k + STEP - 1) / STEP;
  endfunction

  // Monitor: pops one expectation per done pulse; also checks output hold.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_b = 32'd0;
      last_c = 1'b0;
    end else begin
      if (bus.done) begin
        checks = checks + 1;
        if (sbq.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_done at cycle %0d b_out=%h", cycle, bus.b_out);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (bus.b_out !== e.b || bus.shifter_cout !== e.c ||
              (cycle - e.t0) != e.lat) begin
            errors = errors + 1;
            $display("FAIL result: got b=%h c=%b lat=%0d, expected b=%h c=%b lat=%0d",
                     bus.b_out, bus.shifter_cout, cycle - e.t0, e.b, e.c, e.lat);
          end
        end
      end else begin
        checks = checks + 1;
        if (bus.b_out !== last_b || bus.shifter_cout !== last_c) begin
          errors = errors + 1;
          $display("FAIL hold: b_out=%h c=%b changed without done, expected b=%h c=%b",
                   bus.b_out, bus.shifter_cout, last_b, last_c);
        end
      end
      last_b = bus.b_out;
      last_c = bus.shifter_cout;
    end
  end

  task automatic drive_req(
    input logic [1:0]  m,
    input logic [11:0] imm,
    input logic [31:0] rm,
    input logic [7:0]  rs,
    input logic        cin
  );
    bus.mode      = m;
    bus.imm12     = imm;
    bus.rm        = rm;
    bus.rs_amount = rs;
    bus.cin       = cin;
  endtask

  task automatic issue(
    input logic [1:0]  m,
    input logic [11:0] imm,
    input logic [31:0] rm,
    input logic [7:0]  rs,
    input logic        cin,
    input bit          intrude
  );
    exp_t e;
    @(negedge clk);
    drive_req(m, imm, rm, rs, cin);
    bus.start = 1'b1;
    model(m, imm, rm, rs, cin, e.b, e.c, e.lat);
    e.t0 = cycle + 1;
    sbq.push_back(e);
    @(negedge clk);
    checks = checks + 1;
    if (bus.busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL busy_after_start: busy=%b expected 1", bus.busy);
    end
    if (intrude) begin
      drive_req(2'($urandom), 12'($urandom), $urandom, 8'($urandom), 1'($urandom));
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL timeout: done not seen, %0d pending", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run(
    input logic [1:0]  m,
    input logic [11:0] imm,
    input logic [31:0] rm,
    input logic [7:0]  rs,
    input logic        cin,
    input bit          intrude
  );
    issue(m, imm, rm, rs, cin, intrude);
    wait_empty();
  endtask

  task automatic chk_zero(input string name);
    checks = checks + 1;
    if (bus.b_out !== 32'd0 || bus.shifter_cout !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL %s: b=%h c=%b busy=%b done=%b expected all 0",
               name, bus.b_out, bus.shifter_cout, bus.busy, bus.done);
    end
  endtask

  function automatic logic [7:0] pick_rs();
    case ($urandom_range(0, 4))
      0: return 8'd0;
      1: return 8'd32;
      2: return 8'($urandom_range(33, 255));
      default: return 8'($urandom_range(1, 31));
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    drive_req(2'd0, 12'd0, 32'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset_state");
    reset_n = 1'b1;

    run(2'b00, 12'h4FF, 32'h0, 8'd0, 1'b0, 1'b0);
    run(2'b01, 12'h200, 32'h8000000F, 8'd0, 1'b0, 1'b0);
    run(2'b01, 12'h020, 32'h80000001, 8'd0, 1'b0, 1'b0);
    run(2'b01, 12'h060, 32'h00000003, 8'd0, 1'b1, 1'b0);
    run(2'b10, 12'h000, 32'hFFFFFFFF, 8'd40, 1'b1, 1'b0);
    run(2'b10, 12'h000, 32'hFFFFFFFF, 8'd32, 1'b0, 1'b0);
    run(2'b10, 12'h000, 32'hFFFFFFFF, 8'd0, 1'b0, 1'b0);
    run(2'b10, 12'h020, 32'h80000000, 8'd32, 1'b0, 1'b0);
    run(2'b10, 12'h040, 32'h80000000, 8'd200, 1'b0, 1'b0);
    run(2'b10, 12'h060, 32'h80000001, 8'd64, 1'b0, 1'b0);
    run(2'b01, 12'h040, 32'h80000000, 8'd0, 1'b0, 1'b0);
    run(2'b11, 12'h000, 32'hDEADBEEF, 8'd0, 1'b1, 1'b0);
    run(2'b00, 12'h000, 32'h0, 8'd0, 1'b1, 1'b0);
    run(2'b01, 12'h020, 32'h12345678, 8'd0, 1'b0, 1'b1);
    run(2'b01, 12'h000, 32'hCAFEF00D, 8'd0, 1'b0, 1'b1);

    for (int n = 0; n < 150; n++) begin
      run(2'($urandom), 12'($urandom), $urandom, pick_rs(),
          1'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Abort a long LSR#32 with reset mid-SHIFT, then a fresh request.
    run(2'b01, 12'h200, 32'h0000000F, 8'd0, 1'b0, 1'b0);
    issue(2'b01, 12'h020, 32'hFFFFFFFF, 8'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("reset_mid_shift");
    sbq.delete();
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    run(2'b01, 12'h0A0, 32'h80000010, 8'd0, 1'b0, 1'b0);
    run(2'b00, 12'h1F3, 32'h0, 8'd0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
